// File: rtl/shift_exec_pipe.sv
// Two-stage pipelined 32-bit shifter (SLL/SRL/SRA) with valid/ready flow control.
// Stage 1 applies the byte-granular shift (shamt[4:3]); stage 2 applies the bit shift (shamt[2:0]).
module shift_exec_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [4:0]        shamt_i,
  input  logic [TAG_W-1:0]  rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] s_o,
  output logic [TAG_W-1:0]  rd_o
);

  typedef enum logic [1:0] {OpSll = 2'b00, OpSrl = 2'b01, OpSra = 2'b10, OpRsv = 2'b11} op_e;

  logic              s1_valid_q;
  op_e               s1_op_q;
  logic [TAG_W-1:0]  s1_rd_q;
  logic [2:0]        s1_fine_q;
  logic [DATA_W-1:0] s1_coarse_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s_q;
  logic [TAG_W-1:0]  rd_q;

  logic              adv1, adv2, accept;
  op_e               op_in;
  logic [4:0]        coarse_amt;
  logic [DATA_W-1:0] coarse_d;
  logic [DATA_W-1:0] fine_d;

  assign adv2       = ~s2_valid_q | out_ready_i;
  assign adv1       = ~s1_valid_q | adv2;
  assign in_ready_o = adv1 & ~flush_i & rst_ni;
  assign accept     = in_valid_i & in_ready_o;

  assign op_in      = op_e'(op_i);
  assign coarse_amt = {shamt_i[4:3], 3'b000};

  always_comb begin
    coarse_d = a_i;
    case (op_in)
      OpSll:   coarse_d = a_i << coarse_amt;
      OpSrl:   coarse_d = a_i >> coarse_amt;
      OpSra:   coarse_d = $signed(a_i) >>> coarse_amt;
      default: coarse_d = a_i;
    endcase
  end

  // Arithmetic fill stays correct here: the coarse SRA already replicated a[31] into bit 31.
  always_comb begin
    fine_d = '0;
    case (s1_op_q)
      OpSll:   fine_d = s1_coarse_q << s1_fine_q;
      OpSrl:   fine_d = s1_coarse_q >> s1_fine_q;
      OpSra:   fine_d = $signed(s1_coarse_q) >>> s1_fine_q;
      default: fine_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OpSll;
      s1_rd_q     <= '0;
      s1_fine_q   <= '0;
      s1_coarse_q <= '0;
      s2_valid_q  <= 1'b0;
      s_q         <= '0;
      rd_q        <= '0;
    end else if (flush_i) begin
      // Data registers keep their contents; only the valid bits are cleared.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_op_q     <= op_in;
          s1_rd_q     <= rd_i;
          s1_fine_q   <= shamt_i[2:0];
          s1_coarse_q <= coarse_d;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s_q  <= fine_d;
          rd_q <= s1_rd_q;
        end
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign s_o         = s_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Self-checking bench for shift_exec_pipe: scoreboard of in-flight ops plus directed scenarios.
module tb_shift_exec_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic [4:0]  rd_out;

  int total = 0;
  int bad = 0;
  int retired = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  shift_exec_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_i       (op),
    .a_i        (a),
    .shamt_i    (shamt),
    .rd_i       (rd),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .s_o        (s),
    .rd_o       (rd_out)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v,
                                            input logic [4:0] sh);
    case (o)
      2'b00:   ref_shift = v << sh;
      2'b01:   ref_shift = v >> sh;
      2'b10:   ref_shift = $signed(v) >>> sh;
      default: ref_shift = 32'h0;
    endcase
  endfunction

  // Inputs change just after posedge, so values seen here are the ones the next edge samples.
  always @(negedge clk) begin
    logic [36:0] exp_e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        retired++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got s=%h rd=%0d, none expected", s, rd_out);
        end else begin
          exp_e = sb_q.pop_front();
          if ({s, rd_out} !== exp_e) begin
            bad++;
            $display("FAIL sb_result: got s=%h rd=%0d, want s=%h rd=%0d",
                     s, rd_out, exp_e[36:5], exp_e[4:0]);
          end
        end
      end
      if (flush) sb_q.delete();
      if (in_valid && in_ready) sb_q.push_back({ref_shift(op, a, shamt), rd});
    end
  end

  task automatic send(input logic [1:0] o, input logic [31:0] v, input logic [4:0] sh,
                      input logic [4:0] tag, output int waited);
    bit got = 0;
    waited = 0;
    in_valid = 1'b1;
    op = o;
    a = v;
    shamt = sh;
    rd = tag;
    while (!got && waited < 100) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout: op not accepted after %0d cycles, want accept", waited);
    end
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (sb_q.size() == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, s, rd_out} !== 38'h0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b s=%h rd=%0d, want 0/0/0", out_valid, s, rd_out);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single(input logic [1:0] o, input logic [31:0] v, input logic [4:0] sh,
                             input logic [4:0] tag, input logic [31:0] exp_s);
    int w;
    out_ready = 1'b1;
    send(o, v, sh, tag, w);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early op=%0d sh=%0d: out_valid got %b want 0", o, sh, out_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, s, rd_out} !== {1'b1, exp_s, tag}) begin
      bad++;
      $display("FAIL single_result op=%0d a=%h sh=%0d: got v=%b s=%h rd=%0d want v=1 s=%h rd=%0d",
               o, v, sh, out_valid, s, rd_out, exp_s, tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int w;
    int cyc = 0;
    int r0 = retired;
    bit ok;
    out_ready = 1'b1;
    for (int o = 0; o < 3; o++) begin
      for (int sh = 0; sh < 32; sh++) begin
        send(o[1:0], 32'hA5A5A5A5, sh[4:0], sh[4:0], w);
        cyc += w;
      end
    end
    drain(ok);
    total++;
    if (!ok || retired - r0 != 96) begin
      bad++;
      $display("FAIL sweep_count: got %0d results want 96", retired - r0);
    end
    total++;
    if (cyc != 96) begin
      bad++;
      $display("FAIL sweep_throughput: got %0d accept cycles want 96", cyc);
    end
  endtask

  task automatic test_stall();
    int w;
    int r0 = retired;
    bit ok;
    out_ready = 1'b0;
    send(2'b00, 32'h1, 5'd4, 5'd10, w);
    send(2'b01, 32'hF0, 5'd4, 5'd11, w);
    in_valid = 1'b1;
    op = 2'b10;
    a = 32'h80000000;
    shamt = 5'd1;
    rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, s, rd_out} !== {1'b0, 1'b1, 32'h10, 5'd10}) begin
        bad++;
        $display("FAIL stall_hold cyc%0d: got rdy=%b v=%b s=%h rd=%0d want 0/1/00000010/10",
                 i, in_ready, out_valid, s, rd_out);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b10, 32'h80000000, 5'd1, 5'd12, w);
    drain(ok);
    total++;
    if (!ok || retired - r0 != 3) begin
      bad++;
      $display("FAIL stall_release: got %0d results want 3", retired - r0);
    end
  endtask

  task automatic test_flush();
    int w;
    int r0;
    out_ready = 1'b0;
    send(2'b00, 32'h1, 5'd1, 5'd1, w);
    send(2'b00, 32'h1, 5'd2, 5'd2, w);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_kill: out_valid got %b want 0", out_valid);
    end
    out_ready = 1'b1;
    send(2'b00, 32'h3, 5'd9, 5'd20, w);
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, s, rd_out} !== {1'b1, 32'h600, 5'd20}) begin
      bad++;
      $display("FAIL flush_after: got v=%b s=%h rd=%0d want v=1 s=00000600 rd=20",
               out_valid, s, rd_out);
    end
    @(posedge clk);
    #1;
    // Flush coinciding with a retire: the retiring op is delivered, the other is dropped.
    r0 = retired;
    send(2'b01, 32'h100, 5'd8, 5'd3, w);
    send(2'b01, 32'h200, 5'd8, 5'd4, w);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (retired - r0 != 1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_retire: got %0d results v=%b want 1 result v=0",
               retired - r0, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int seen = 0;
    out_ready = 1'b0;
    send(2'b00, 32'hFF, 5'd3, 5'd7, w);
    send(2'b10, 32'hF000000F, 5'd5, 5'd8, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, s, rd_out} !== 38'h0) begin
      bad++;
      $display("FAIL reset_mid: got v=%b s=%h rd=%0d want 0/0/0", out_valid, s, rd_out);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_stale: got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    a = 32'h0;
    shamt = 5'd0;
    rd = 5'd0;
    test_reset();
    test_single(2'b00, 32'h00000001, 5'd31, 5'd1, 32'h80000000);
    test_single(2'b01, 32'h80000000, 5'd31, 5'd2, 32'h00000001);
    test_single(2'b10, 32'h80000000, 5'd31, 5'd3, 32'hFFFFFFFF);
    test_single(2'b10, 32'h7FFF0000, 5'd4, 5'd4, 32'h07FFF000);
    test_single(2'b11, 32'hDEADBEEF, 5'd5, 5'd5, 32'h00000000);
    test_single(2'b10, 32'h9ABCDEF0, 5'd0, 5'd6, 32'h9ABCDEF0);
    test_single(2'b01, 32'h9ABCDEF0, 5'd12, 5'd7, 32'h0009ABCD);
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
